// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// The response FIFO entry holds the instruction word together with its PC.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle of the fetch stage: instruction-memory request/response,
// redirect input from branch resolution and the valid/ready path to decode.
interface inst_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries buffering instruction-memory
// responses; clear empties it in one cycle and overrides push/pop.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          clear,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is reset too so the decode-facing outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage: owns the PC, issues credit-limited fetches,
// buffers in-order responses and flushes stale work on branch redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fetch_en,
    inst_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] rsp_dec;
    logic [CW:0]   credit_used;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_keep;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  fifo_head;

    assign redirect_target = align_pc(bus.redirect_pc);
    assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
    assign rsp_dec         = CW'(bus.imem_rsp_valid);
    assign req_fire        = req_valid & bus.imem_req_ready;
    assign rsp_keep        = bus.imem_rsp_valid & (drop_cnt == '0);
    assign fifo_push       = rsp_keep & ~bus.redirect_valid;
    assign fifo_pop        = ~fifo_empty & bus.inst_ready & ~bus.redirect_valid;
    assign rsp_entry       = '{pc: rsp_pc, inst: bus.imem_rsp_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outstanding plus buffered fetches never exceed the FIFO depth, so every
    // response has a slot waiting and the memory side needs no back-pressure.
    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fetch_en) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!fetch_en) begin
                    state_next = S_IDLE;
                end
                req_valid = ~bus.redirect_valid
                          & (credit_used < (CW + 1)'(FIFO_DEPTH));
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A redirect wins over everything: the in-flight requests still to answer
    // (minus one arriving right now) become words to throw away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redirect_valid) begin
            pc          <= redirect_target;
            rsp_pc      <= redirect_target;
            outstanding <= outstanding - rsp_dec;
            drop_cnt    <= outstanding - rsp_dec;
        end else begin
            if (req_fire) begin
                pc <= pc + PC_STEP;
            end
            outstanding <= outstanding + CW'(req_fire) - rsp_dec;
            if (bus.imem_rsp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end else begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .clear     (bus.redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = ~fifo_empty;
    assign bus.inst           = fifo_head.inst;
    assign bus.inst_pc        = fifo_head.pc;

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credit_used <= (CW + 1)'(FIFO_DEPTH));
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (outstanding != '0));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt <= outstanding);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full));

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: an epoch-tagged memory/instruction-stream
// model predicts every output each cycle under directed and random traffic.
module tb_inst_fetch;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_inst_t;

    logic clk = 1'b0;
    logic rst_n;
    logic fetch_en;

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_en (fetch_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    mem_req_t    mem_q[$];
    exp_inst_t   exp_q[$];
    int          tests     = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          epoch     = 0;
    int          latency   = 1;
    int          last_due  = 0;
    int          req_count = 0;
    int          pop_count = 0;
    logic        run_model = 1'b0;
    logic [31:0] exp_pc    = RST_PC;
    logic        obs_fire;
    logic        obs_inst_valid;
    logic [31:0] obs_fire_addr;
    logic [31:0] last_pop_pc;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance it.
    task automatic applyStimulus(input logic req_rdy, input logic inst_rdy,
                                 input logic redir, input logic [31:0] target);
        logic     rsp_now;
        logic     exp_req_valid;
        logic     exp_inst_valid;
        mem_req_t head;
        head = '{32'h0, -1, 0};
        bus.imem_req_ready = req_rdy;
        bus.inst_ready     = inst_rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = target;
        rsp_now = (mem_q.size() > 0) && (mem_q[0].due == cyc);
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? (mem_q[0].addr ^ KEY) : 32'h0;
        #1;
        exp_req_valid  = run_model && !redir && (mem_q.size() + exp_q.size() < 2);
        exp_inst_valid = (exp_q.size() > 0);
        checkOutput("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_req_valid});
        checkOutput("req_addr", bus.imem_req_addr, exp_pc);
        checkOutput("inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_inst_valid});
        if (exp_inst_valid) begin
            checkOutput("inst_pc", bus.inst_pc, exp_q[0].pc);
            checkOutput("inst", bus.inst, exp_q[0].word);
        end
        obs_fire       = bus.imem_req_valid && req_rdy;
        obs_fire_addr  = bus.imem_req_addr;
        obs_inst_valid = bus.inst_valid;
        if (bus.inst_valid && inst_rdy && !redir) begin
            pop_count++;
            last_pop_pc = bus.inst_pc;
        end
        if (obs_fire) req_count++;
        if (rsp_now) head = mem_q.pop_front();
        if (exp_req_valid && req_rdy) begin
            last_due = (cyc + latency > last_due + 1) ? cyc + latency : last_due + 1;
            mem_q.push_back('{exp_pc, epoch, last_due});
            exp_pc += 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_pc = {target[31:2], 2'b00};
        end else begin
            if (exp_inst_valid && inst_rdy) void'(exp_q.pop_front());
            if (rsp_now && head.epoch == epoch) exp_q.push_back('{head.addr, head.addr ^ KEY});
        end
        run_model = fetch_en;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitFirstPop(input string tag, input logic [31:0] expected_pc);
        int   start;
        logic seen;
        start = pop_count;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (pop_count > start) seen = 1'b1;
        end
        checkOutput({tag, "_seen"}, {31'b0, seen}, 32'd1);
        if (seen) checkOutput({tag, "_pc"}, last_pop_pc, expected_pc);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   first_req;
        int   first_valid;
        int   reqs_before;
        logic found;

        rst_n              = 1'b0;
        fetch_en           = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        #1;
        checkOutput("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        checkOutput("rst_req_addr", bus.imem_req_addr, RST_PC);
        checkOutput("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        checkOutput("rst_inst", bus.inst, 32'h0);
        checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        fetch_en = 1'b1;

        // Streaming with an always-ready memory and decode.
        first_req   = -1;
        first_valid = -1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_fire && first_req < 0) first_req = cyc - 1;
            if (obs_inst_valid && first_valid < 0) first_valid = cyc - 1;
        end
        checkOutput("first_inst_latency", first_valid - first_req, 32'd2);

        // Decode stall: credit must stop requests.
        reqs_before = req_count;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_reqs_le2", {31'b0, (req_count - reqs_before) <= 2}, 32'd1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Three-cycle memory, redirect with two fetches in flight.
        latency = 3;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2) found = 1'b1;
            else applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        end
        checkOutput("two_outstanding_found", {31'b0, found}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        waitFirstPop("redirect_100", 32'h0000_0100);

        // Unaligned target, and a target that wraps the address space.
        latency = 1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        waitFirstPop("redirect_203", 32'h0000_0200);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA);
        waitFirstPop("redirect_wrap", 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a response and a pop of a buffered entry.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (exp_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due == cyc) found = 1'b1;
            else applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        end
        checkOutput("coincide_found", {31'b0, found}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("coincide_valid_next", {31'b0, obs_inst_valid}, 32'd0);
        waitFirstPop("coincide_target", 32'h0000_0300);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (mem_q.size() == 0 && $urandom_range(0, 7) == 0) latency = $urandom_range(1, 4);
            fetch_en = ($urandom_range(0, 15) != 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0, $urandom);
        end

        // Asynchronous reset in the middle of a stream.
        fetch_en = 1'b1;
        latency  = 1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        checkOutput("arst_req_addr", bus.imem_req_addr, RST_PC);
        checkOutput("arst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        checkOutput("arst_inst", bus.inst, 32'h0);
        checkOutput("arst_inst_pc", bus.inst_pc, 32'h0);
        mem_q.delete();
        exp_q.delete();
        run_model          = 1'b0;
        exp_pc             = RST_PC;
        bus.imem_rsp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_fire) found = 1'b1;
        end
        checkOutput("post_rst_fire_seen", {31'b0, found}, 32'd1);
        if (found) checkOutput("post_rst_first_addr", obs_fire_addr, RST_PC);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
